// File: rtl/sample_packer_3p_pkg.sv
// Shared FIR constants: sample width, parallelism factor and phase encoding
// used by the 3-parallel unfolded FIR and its input packer.
package sample_packer_3p_pkg;

  localparam int NB  = 7;
  localparam int PAR = 3;

  // Position of the next incoming sample within the current 3-sample group.
  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_e;

endpackage : sample_packer_3p_pkg

// File: rtl/sample_packer_3p_if.sv
// Serial-in / 3-lane-out bus of the sample packer.
interface sample_packer_3p_if
  import sample_packer_3p_pkg::*;
#(
  parameter int NB_P = NB
);

  logic [NB_P-1:0] DIN;
  logic            VIN;
  logic            FLUSH;
  logic [NB_P-1:0] DOUT_3K;
  logic [NB_P-1:0] DOUT_3K_1;
  logic [NB_P-1:0] DOUT_3K_2;
  logic            VOUT;
  logic            BUSY;

  // Producer side: drives samples, observes groups.
  modport master (
    output DIN, VIN, FLUSH,
    input  DOUT_3K, DOUT_3K_1, DOUT_3K_2, VOUT, BUSY
  );

  // Packer side.
  modport slave (
    input  DIN, VIN, FLUSH,
    output DOUT_3K, DOUT_3K_1, DOUT_3K_2, VOUT, BUSY
  );

endinterface : sample_packer_3p_if

// File: rtl/sample_packer_3p_reg_n.sv
// NB-bit register with load enable and synchronous active-high reset.
module reg_n #(
  parameter int NB = 7
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          en,
  input  logic [NB-1:0] d,
  output logic [NB-1:0] q
);

  // Load on enable, otherwise hold; reset clears.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q <= {NB{1'b0}};
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule : reg_n

// File: rtl/sample_packer_3p.sv
// Packs three consecutive valid serial samples into one parallel group for
// the 3-parallel unfolded FIR. A flush closes a partial group with the
// missing lanes zeroed. Lanes and VOUT are registered: one clock latency.
module sample_packer_3p
  import sample_packer_3p_pkg::*;
#(
  parameter int NB = sample_packer_3p_pkg::NB
) (
  input logic               CLK,
  input logic               RST,
  sample_packer_3p_if.slave bus
);

  phase_e          phase_r;
  phase_e          phase_nxt_s;
  logic [NB-1:0]   hold0_r;
  logic [NB-1:0]   hold1_r;
  logic [NB-1:0]   hold0_nxt_s;
  logic [NB-1:0]   hold1_nxt_s;
  logic            emit_s;
  logic [NB-1:0]   lane_d_s [PAR];
  logic [NB-1:0]   lane_q_s [PAR];
  logic            vout_r;

  // Phase register and hold slots; a reset discards any partial group.
  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_r <= PH0;
      hold0_r <= {NB{1'b0}};
      hold1_r <= {NB{1'b0}};
      vout_r  <= 1'b0;
    end else begin
      phase_r <= phase_nxt_s;
      hold0_r <= hold0_nxt_s;
      hold1_r <= hold1_nxt_s;
      vout_r  <= emit_s;
    end
  end

  // Next phase, slot capture and group emission. A sample arriving with
  // FLUSH is taken first; whatever is then held is emitted zero-padded.
  always_comb begin
    phase_nxt_s = phase_r;
    hold0_nxt_s = hold0_r;
    hold1_nxt_s = hold1_r;
    emit_s      = 1'b0;
    lane_d_s[0] = {NB{1'b0}};
    lane_d_s[1] = {NB{1'b0}};
    lane_d_s[2] = {NB{1'b0}};
    case (phase_r)
      PH0: begin
        if (bus.VIN) begin
          hold0_nxt_s = bus.DIN;
          if (bus.FLUSH) begin
            emit_s      = 1'b1;
            lane_d_s[0] = bus.DIN;
            phase_nxt_s = PH0;
          end else begin
            phase_nxt_s = PH1;
          end
        end else begin
          phase_nxt_s = PH0;
        end
      end
      PH1: begin
        if (bus.VIN) begin
          hold1_nxt_s = bus.DIN;
          if (bus.FLUSH) begin
            emit_s      = 1'b1;
            lane_d_s[0] = hold0_r;
            lane_d_s[1] = bus.DIN;
            phase_nxt_s = PH0;
          end else begin
            phase_nxt_s = PH2;
          end
        end else if (bus.FLUSH) begin
          emit_s      = 1'b1;
          lane_d_s[0] = hold0_r;
          phase_nxt_s = PH0;
        end else begin
          phase_nxt_s = PH1;
        end
      end
      PH2: begin
        if (bus.VIN) begin
          emit_s      = 1'b1;
          lane_d_s[0] = hold0_r;
          lane_d_s[1] = hold1_r;
          lane_d_s[2] = bus.DIN;
          phase_nxt_s = PH0;
        end else if (bus.FLUSH) begin
          emit_s      = 1'b1;
          lane_d_s[0] = hold0_r;
          lane_d_s[1] = hold1_r;
          phase_nxt_s = PH0;
        end else begin
          phase_nxt_s = PH2;
        end
      end
      default: begin
        phase_nxt_s = PH0;
      end
    endcase
  end

  // One enabled register per output lane.
  for (genvar g = 0; g < PAR; g++) begin : g_lane
    reg_n #(.NB(NB)) u_lane (
      .CLK (CLK),
      .RST (RST),
      .en  (emit_s),
      .d   (lane_d_s[g]),
      .q   (lane_q_s[g])
    );
  end

  assign bus.DOUT_3K   = lane_q_s[0];
  assign bus.DOUT_3K_1 = lane_q_s[1];
  assign bus.DOUT_3K_2 = lane_q_s[2];
  assign bus.VOUT      = vout_r;
  assign bus.BUSY      = (phase_r != PH0);

endmodule : sample_packer_3p

// File: doc/sample_packer_3p.md
SAMPLE_PACKER_3P -- requirements
Module: sample_packer_3p

Interface
REQ-001 SHALL have parameter NB, default 7, sample width in bits (two's complement).
REQ-002 SHALL have port CLK  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port DIN  in  NB  serial input sample.
REQ-005 SHALL have port VIN  in  1  DIN valid this cycle.
REQ-006 SHALL have port FLUSH  in  1  close the current partial group, zero-padded.
REQ-007 SHALL have port DOUT_3K  out  NB  lane 0, oldest sample x[3k].
REQ-008 SHALL have port DOUT_3K_1  out  NB  lane 1, x[3k+1].
REQ-009 SHALL have port DOUT_3K_2  out  NB  lane 2, newest sample x[3k+2].
REQ-010 SHALL have port VOUT  out  1  one-cycle pulse: lanes hold a new 3-sample group.
REQ-011 SHALL have port BUSY  out  1  high while a partial group is held (phase != 0).

Function
REQ-012 SHALL pack three consecutive valid serial samples into one parallel group for the 3-parallel unfolded FIR.
REQ-013 SHALL keep a phase counter 0->1->2->0 that advances only on cycles with VIN=1.
REQ-014 SHALL capture DIN into hold slot [phase] when VIN=1 and phase is 0 or 1.
REQ-015 SHALL, when VIN=1 at phase 2, register hold0, hold1 and DIN onto lanes 0/1/2 and pulse VOUT on the next cycle.
REQ-016 SHALL have a latency from the third sample's VIN cycle to VOUT=1 of exactly one clock.
REQ-017 SHALL hold lane values stable between groups; VOUT=1 SHALL last exactly one cycle per group.
REQ-018 SHALL tolerate gaps (VIN=0) of any length between samples, holding phase and slots.
REQ-019 SHALL, on FLUSH=1, VIN=0 and phase in {1,2}, emit the held samples with missing lanes forced to 0, pulse VOUT next cycle and return phase to 0.
REQ-020 SHALL, on FLUSH=1 with VIN=1, include DIN first; a group left partial is then flushed zero-padded in the same cycle. If DIN completes the group, exactly one normal group is emitted.
REQ-021 SHALL treat FLUSH=1 at phase 0 with VIN=0 as a no-op: no VOUT, lanes unchanged.
REQ-022 SHALL sustain back-to-back VIN=1 at full rate: one group every 3 cycles, no sample loss.
REQ-023 SHALL not sign-extend, modify or saturate data; lanes carry DIN bits verbatim.
REQ-024 SHALL drive BUSY combinationally from the phase register.

Reset
REQ-025 SHALL, with RST=1 at a rising edge, set phase=0, hold slots=0, all lanes=0, VOUT=0, BUSY=0.
REQ-026 SHALL discard a partial group when reset arrives mid-group; no VOUT for it after reset.
REQ-027 SHALL give RST priority over VIN and FLUSH in the same cycle.

Structure
REQ-028 SHALL take NB=7, the parallelism factor 3 and the phase encoding (2-bit, values 0..2) from the shared FIR package used by the unfolded FIR.
REQ-029 SHALL instance sub-module reg_n (NB-bit register with enable and sync reset) once per output lane; phase and hold logic stay in this module.

Verification
REQ-030 SHALL check: RST=1 for 2 cycles, then VIN=1 with DIN=1,2,3 -> one cycle after the DIN=3 cycle, VOUT=1 with lanes 1/2/3.
REQ-031 SHALL check: continuous VIN=1 with DIN=1..9 -> VOUT pulses on 3 cycles spaced 3 apart, with groups (1,2,3), (4,5,6), (7,8,9).
REQ-032 SHALL check: DIN=10, VIN=0 for 5 cycles, then DIN=20, 30 -> group (10,20,30); no VOUT during the gap.
REQ-033 SHALL check: DIN=-5 (0x7B), VIN=1 for one cycle, then FLUSH=1 with VIN=0 -> next cycle VOUT=1 with lanes (0x7B,0,0) and BUSY=0.
REQ-034 SHALL check: samples 7, 8 accepted, then RST=1 for 1 cycle, then 1,2,3 -> only group (1,2,3) appears; 7 and 8 are never output.
REQ-035 SHALL check: FLUSH=1 together with the third sample DIN=6 after 4, 5 -> exactly one VOUT with (4,5,6).
